// File: rtl/sap_ctrl_seq.sv
// SAP-1 controller-sequencer: six-state ring counter clocked on the falling edge,
// opcode decode and the 12-bit control word that gates the datapath.
module sap_ctrl_seq #(
    parameter int OP_W     = 4,
    parameter bit SKIP_NOP = 1'b0
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [OP_W-1:0] opcode,
    output logic [11:0]     ctrl,
    output logic [5:0]      t_state,
    output logic            halted
);

    localparam logic [11:0] CP = 12'h800;
    localparam logic [11:0] EP = 12'h400;
    localparam logic [11:0] LM = 12'h200;
    localparam logic [11:0] CE = 12'h100;
    localparam logic [11:0] LI = 12'h080;
    localparam logic [11:0] EI = 12'h040;
    localparam logic [11:0] LA = 12'h020;
    localparam logic [11:0] EA = 12'h010;
    localparam logic [11:0] SU = 12'h008;
    localparam logic [11:0] EU = 12'h004;
    localparam logic [11:0] LB = 12'h002;
    localparam logic [11:0] LO = 12'h001;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'b1110);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'b1111);

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [11:0] ctrl_next;
    logic [11:0] w4, w5, w6;
    logic        is_hlt;

    // Falling-edge update keeps ctrl settled across every rising edge.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= S_T1;
        end else begin
            state_reg <= state_next;
        end
    end

    // Execute-phase words for the current opcode.
    always_comb begin
        w4     = '0;
        w5     = '0;
        w6     = '0;
        is_hlt = 1'b0;
        case (opcode)
            OP_LDA: begin w4 = EI | LM; w5 = CE | LA; end
            OP_ADD: begin w4 = EI | LM; w5 = CE | LB; w6 = LA | EU; end
            OP_SUB: begin w4 = EI | LM; w5 = CE | LB; w6 = LA | SU | EU; end
            OP_OUT: begin w4 = EA | LO; end
            OP_HLT: begin is_hlt = 1'b1; end
            default: ;
        endcase
    end

    // Early return happens when every remaining word of the instruction is zero.
    always_comb begin
        state_next = state_reg;
        ctrl_next  = '0;
        case (state_reg)
            S_T1: begin
                ctrl_next  = EP | LM;
                state_next = S_T2;
            end
            S_T2: begin
                ctrl_next  = CP;
                state_next = S_T3;
            end
            S_T3: begin
                ctrl_next  = CE | LI;
                if (SKIP_NOP && !is_hlt && ((w4 | w5 | w6) == 12'h000))
                    state_next = S_T1;
                else
                    state_next = S_T4;
            end
            S_T4: begin
                ctrl_next = w4;
                if (is_hlt)
                    state_next = S_HALT;
                else if (SKIP_NOP && ((w5 | w6) == 12'h000))
                    state_next = S_T1;
                else
                    state_next = S_T5;
            end
            S_T5: begin
                ctrl_next = w5;
                if (SKIP_NOP && (w6 == 12'h000))
                    state_next = S_T1;
                else
                    state_next = S_T6;
            end
            S_T6: begin
                ctrl_next  = w6;
                state_next = S_T1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_T1;
            end
        endcase
    end

    assign ctrl   = clr ? 12'h000 : ctrl_next;
    assign halted = (state_reg == S_HALT);

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_tstate
            assign t_state[gi] = (state_reg == state_t'(3'(gi)));
        end
    endgenerate

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
Controller-sequencer for the SAP-1 datapath inside top_rework. It contains a ring counter that steps through six T-states, and it decodes the 4-bit opcode held in the instruction register. From these it drives the 12-bit control word that gates every bus driver and register load. The state advances on the falling edge of clk, so the control word is stable at each rising edge, where the datapath registers load.

Parameters:
OP_W, 4, opcode width taken from the upper IR nibble.
SKIP_NOP, 0, when 1 the sequencer returns to T1 as soon as an instruction's remaining T-states are all no-ops (variable-length machine cycle).

Ports:
clk  input  1  system clock; state register updates on negedge.
clr  input  1  asynchronous, active-high reset.
opcode  input  OP_W  IR[7:4] from the instruction register.
ctrl  output  12  control word, all bits active-high: [11]Cp [10]Ep [9]Lm [8]CE [7]Li [6]Ei [5]La [4]Ea [3]Su [2]Eu [1]Lb [0]Lo.
t_state  output  6  one-hot T-state, bit0 = T1 … bit5 = T6.
halted  output  1  high once HLT has been decoded.

Behaviour:
- Reset (clr=1, asynchronous): state = T1, t_state = 6'b000001, halted = 0. ctrl is forced to 12'h000 for as long as clr is high, so nothing loads during clear.
- After clr falls, ctrl = 12'h600 (T1 word) until the first negedge.
- Ring counter: T1→T2→…→T6→T1, one step per negedge clk.
- ctrl is combinational from the registered state and opcode. Opcode is sampled only in T4–T6; it is loaded at the T3 posedge and is stable from T4 onward.
- Fetch, common to all instructions: T1 = 12'h600 (Ep,Lm); T2 = 12'h800 (Cp); T3 = 12'h180 (CE,Li).
- Opcodes and their T4 / T5 / T6 words:
  - LDA 0000: T4 12'h240 (Ei,Lm); T5 12'h120 (CE,La); T6 12'h000.
  - ADD 0001: T4 12'h240; T5 12'h102 (CE,Lb); T6 12'h024 (La,Eu).
  - SUB 0010: T4 12'h240; T5 12'h102; T6 12'h02C (La,Su,Eu).
  - OUT 1110: T4 12'h011 (Ea,Lo); T5 12'h000; T6 12'h000.
  - HLT 1111: ctrl = 12'h000 in T4. At the next negedge the state enters HALT.
  - Any other opcode: NOP, ctrl = 12'h000 for T4–T6.
- HALT state: t_state = 6'b000000, ctrl = 12'h000, halted = 1. HALT is held until clr; only clr exits it.
- SKIP_NOP = 1, early return to T1 at the next negedge:
  - LDA: after T5.
  - OUT: after T4.
  - NOP opcodes: after T3.
  - ADD and SUB: no change.
  - HLT: unchanged, goes T4→HALT.
- Invariants:
  - At most one bus enable (Ep, Ei, Ea, Eu) is high in any state.
  - ctrl never changes between a negedge and the following posedge other than through clr.
  - t_state is always one-hot or all-zero (HALT).
- Reset mid-instruction, in any state including HALT: immediate return to T1 with ctrl = 0. The previous opcode is ignored until the next T4.
- An opcode change during T4–T6 is followed combinationally. The datapath guarantees IR is stable in those states; the bench must not rely on this.

Test Plan:
1. Reset and fetch: clr high for 10 ns, then low with opcode=0000 → t_state 000001, ctrl 000 during clr, 600 after release. Then 800 and 180 on successive negedges.
2. LDA/ADD/SUB sequencing, SKIP_NOP=0:
   - opcode 0001 → T4..T6 = 240, 102, 024, then T1 (600).
   - opcode 0010 → T6 = 02C.
   - opcode 0000 → T6 = 000.
   - Every instruction spans exactly 6 negedges.
3. OUT then HLT:
   - OUT (1110) → T4 = 011.
   - HLT (1111) → after T4, halted=1, t_state=0, ctrl=000 held for 20 cycles.
   - Pulse clr → halted=0, T1, ctrl 600 on release.
4. SKIP_NOP=1, LDA/OUT/undefined → returns to T1 after:
   - LDA: 5 states.
   - OUT: 4 states.
   - Opcode 0101: 3 states.
   - ADD still takes 6.
5. Async reset mid-cycle: assert clr between edges in T5 of ADD → t_state=000001 and ctrl=000 within the same timestep, before any clock edge. After release the sequence restarts at T1.
6. Integration: instantiate in top_rework with program LDA 9, ADD A, SUB B, OUT, HLT, where mem[9]=5, mem[A]=3, mem[B]=2 → out = 8'b00000110. halted is asserted and the bus-enable one-hot assertion holds for the whole run.
